// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller:
//   reg_idx_t           - 4-bit architectural register index
//   hz_state_t          - controller FSM state (RUN, MEM_WAIT)
//   MEM_TIMEOUT_DEFAULT - default maximum number of memory wait cycles
//   load_use_hit()      - load-use hazard detection between Decode and Execute
package hazard_pkg;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

    // A load in Execute whose destination is read by the Decode instruction.
    // Register 0 is an ordinary register here, so no zero-index exclusion.
    function automatic logic load_use_hit(
        input logic     is_load,
        input reg_idx_t rd,
        input reg_idx_t ra,
        input logic     use_a,
        input reg_idx_t rb,
        input logic     use_b
    );
        return is_load & ((use_a & (ra == rd)) | (use_b & (rb == rd)));
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
// Lost-cycle performance counters for the hazard controller.
// Ports:
//   clk, rst_n  - core clock, asynchronous active-low reset
//   stall_any   - at least one pipeline register is held this cycle
//   flush_any   - at least one pipeline register is flushed this cycle
//   stall_cnt   - cycles with any stall (wraps modulo 2^CNT_W)
//   flush_cnt   - cycles with any flush (wraps modulo 2^CNT_W)
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_any,
    input  logic             flush_any,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Stall-cycle counter, wraps naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_any) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush-cycle counter, wraps naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_any) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard controller for the 5-stage core: load-use stalls, taken-branch
// flushes and a full-pipeline freeze while a data-memory access waits for ack.
// Optional feature macro: HAZARD_PERF_CNT_EN (instantiates the lost-cycle
// counters; when undefined the counter outputs are tied to zero).
// Ports:
//   clk, rst_n                 - core clock, asynchronous active-low reset
//   RegA_D, RegB_D, useA_D/B_D - Decode source registers and their use flags
//   Rd_E, memtoreg_E           - Execute destination register, Execute is a load
//   branch_taken_E             - branch/PC write resolved taken in Execute
//   mem_req_M, mem_ack         - Memory-stage data access request and completion
//   stall_F/D/E/M              - hold the corresponding pipeline register
//   flush_D/E                  - turn the corresponding pipeline register into a bubble
//   mem_timeout                - sticky: memory wait reached MEM_TIMEOUT cycles
//   stall_cnt, flush_cnt       - performance counters
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_idx_t         RegA_D,
    input  reg_idx_t         RegB_D,
    input  logic             useA_D,
    input  logic             useB_D,
    input  reg_idx_t         Rd_E,
    input  logic             memtoreg_E,
    input  logic             branch_taken_E,
    input  logic             mem_req_M,
    input  logic             mem_ack,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

    hz_state_t         state_r;
    hz_state_t         state_next_s;
    logic [WCNT_W-1:0] wcnt_r;
    logic [WCNT_W-1:0] wcnt_next_s;
    logic              mem_timeout_r;
    logic              lu_s;
    logic              mem_stall_s;

    assign lu_s        = load_use_hit(memtoreg_E, Rd_E, RegA_D, useA_D, RegB_D, useB_D);
    // First cycle of an unacknowledged access: still RUN, so stall combinationally.
    assign mem_stall_s = mem_req_M & ~mem_ack;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_next_s = MEM_WAIT;
                end else begin
                    state_next_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = MEM_WAIT;
                end
            end
            default: state_next_s = RUN;
        endcase
    end

    // Stall/flush outputs; priority is memory wait, then taken branch, then load-use.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    stall_E = 1'b1;
                    stall_M = 1'b1;
                end else if (branch_taken_E) begin
                    // Flushing Decode also resolves any concurrent load-use.
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (lu_s) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end else begin
                    stall_F = 1'b0;
                end
            end
            MEM_WAIT: begin
                // Hazard inputs are frozen here; the pipeline releases in the ack cycle.
                if (!mem_ack) begin
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    stall_E = 1'b1;
                    stall_M = 1'b1;
                end else begin
                    stall_F = 1'b0;
                end
            end
            default: begin
                stall_F = 1'b0;
            end
        endcase
    end

    // Wait-counter next value: cleared on entry, saturating count while waiting.
    always_comb begin
        wcnt_next_s = wcnt_r;
        if ((state_r == RUN) && (state_next_s == MEM_WAIT)) begin
            wcnt_next_s = {WCNT_W{1'b0}};
        end else if ((state_r == MEM_WAIT) && (wcnt_r != WCNT_MAX)) begin
            wcnt_next_s = wcnt_r + WCNT_W'(1);
        end else begin
            wcnt_next_s = wcnt_r;
        end
    end

    // Wait-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_r <= {WCNT_W{1'b0}};
        end else begin
            wcnt_r <= wcnt_next_s;
        end
    end

    // Sticky timeout flag; the FSM itself keeps waiting for the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout_r <= 1'b0;
        end else if ((state_r == MEM_WAIT) && (wcnt_next_s == WCNT_MAX)) begin
            mem_timeout_r <= 1'b1;
        end else begin
            mem_timeout_r <= mem_timeout_r;
        end
    end

    assign mem_timeout = mem_timeout_r;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_any_s;
    logic flush_any_s;

    assign stall_any_s = stall_F | stall_D | stall_E | stall_M;
    assign flush_any_s = flush_D | flush_E;

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_any (stall_any_s),
        .flush_any (flush_any_s),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int T  = 15;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    RegA_D = 4'd0, RegB_D = 4'd0, Rd_E = 4'd0;
    logic          useA_D = 1'b0, useB_D = 1'b0, memtoreg_E = 1'b0;
    logic          branch_taken_E = 1'b0, mem_req_M = 1'b0, mem_ack = 1'b0;
    logic          stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit            m_wait;
    int            m_wcnt;
    bit            m_to;
    logic [CW-1:0] m_sc, m_fc;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegA_D(RegA_D), .RegB_D(RegB_D), .useA_D(useA_D), .useB_D(useB_D),
        .Rd_E(Rd_E), .memtoreg_E(memtoreg_E), .branch_taken_E(branch_taken_E),
        .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,mem_timeout}
    function automatic logic [6:0] model_out();
        logic       lu;
        logic [6:0] r;
        lu = memtoreg_E && ((useA_D && (RegA_D == Rd_E)) || (useB_D && (RegB_D == Rd_E)));
        r = 7'd0;
        r[0] = m_to;
        if (m_wait) begin
            if (!mem_ack) r[6:3] = 4'b1111;
        end else if (mem_req_M && !mem_ack) begin
            r[6:3] = 4'b1111;
        end else if (branch_taken_E) begin
            r[2:1] = 2'b11;
        end else if (lu) begin
            r[6:5] = 2'b11;
            r[1]   = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_wcnt = 0; m_to = 1'b0; m_sc = '0; m_fc = '0;
    endtask

    task automatic model_tick();
        logic [6:0] o;
        o = model_out();
        if (|o[6:3]) m_sc = m_sc + 1;
        if (|o[2:1]) m_fc = m_fc + 1;
        if (m_wait) begin
            if (m_wcnt < T) m_wcnt = m_wcnt + 1;
            if (m_wcnt == T) m_to = 1'b1;
            if (mem_ack) m_wait = 1'b0;
        end else if (mem_req_M && !mem_ack) begin
            m_wait = 1'b1;
            m_wcnt = 0;
        end
    endtask

    task automatic set_idle();
        RegA_D = 4'd0; RegB_D = 4'd0; Rd_E = 4'd0; useA_D = 1'b0; useB_D = 1'b0;
        memtoreg_E = 1'b0; branch_taken_E = 1'b0; mem_req_M = 1'b0; mem_ack = 1'b0;
    endtask

    // Samples the DUT mid-cycle, then advances one clock and the model with it.
    task automatic run_cycle(output logic [6:0] obs, output logic [6:0] exp,
                             output logic [CW-1:0] osc, output logic [CW-1:0] ofc,
                             output logic [CW-1:0] esc, output logic [CW-1:0] efc);
        @(negedge clk);
        obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout};
        exp = model_out();
        osc = stall_cnt;
        ofc = flush_cnt;
`ifdef HAZARD_PERF_CNT_EN
        esc = m_sc;
        efc = m_fc;
`else
        esc = '0;
        efc = '0;
`endif
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if ({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout} !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout});
        end
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        set_idle();
        memtoreg_E = 1'b1; Rd_E = 4'd1; RegA_D = 4'd1; useA_D = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b1100010) begin n_errors++; $display("FAIL lu_stall: got %b want 1100010", o); end
        memtoreg_E = 1'b0;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL lu_release: got %b want 0000000", o); end
        memtoreg_E = 1'b1; useA_D = 1'b0;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL lu_unused_src: got %b want 0000000", o); end
        set_idle();
        memtoreg_E = 1'b1; Rd_E = 4'd0; RegB_D = 4'd0; useB_D = 1'b1; RegA_D = 4'd5; useA_D = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b1100010) begin n_errors++; $display("FAIL lu_reg0_srcB: got %b want 1100010", o); end
        set_idle();
    endtask

    task automatic test_branch_lu();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        set_idle();
        memtoreg_E = 1'b1; Rd_E = 4'd3; RegA_D = 4'd3; useA_D = 1'b1; branch_taken_E = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000110) begin n_errors++; $display("FAIL branch_lu: got %b want 0000110", o); end
        set_idle();
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL branch_pulse_width: got %b want 0000000", o); end
    endtask

    task automatic test_mem_wait();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        set_idle();
        mem_req_M = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(o, e, a, b, c, d);
            n_checks++;
            if (o !== 7'b1111000) begin n_errors++; $display("FAIL mem_wait_c%0d: got %b want 1111000", i, o); end
        end
        mem_ack = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL mem_ack_release: got %b want 0000000", o); end
        // zero-wait access, then idle must show no stall (FSM stayed in RUN)
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL mem_zero_wait: got %b want 0000000", o); end
        set_idle();
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL mem_zero_wait_after: got %b want 0000000", o); end
    endtask

    task automatic test_timeout();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        logic [6:0] want;
        set_idle();
        mem_req_M = 1'b1;
        // cycle 1 stalls from RUN; cycles 2..20 are wait cycles; the 15th is cycle 16
        for (int i = 1; i <= 20; i++) begin
            want = (i >= 17) ? 7'b1111001 : 7'b1111000;
            run_cycle(o, e, a, b, c, d);
            n_checks++;
            if (o !== want) begin n_errors++; $display("FAIL timeout_c%0d: got %b want %b", i, o, want); end
        end
        mem_ack = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000001) begin n_errors++; $display("FAIL timeout_ack: got %b want 0000001", o); end
        set_idle();
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000001) begin n_errors++; $display("FAIL timeout_sticky: got %b want 0000001", o); end
        do_reset();
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL timeout_cleared: got %b want 0000000", o); end
    endtask

    task automatic test_reset_midwait();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        set_idle();
        mem_req_M = 1'b1;
        run_cycle(o, e, a, b, c, d);
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b1111000) begin n_errors++; $display("FAIL midwait_entry: got %b want 1111000", o); end
        rst_n = 1'b0;
        mem_req_M = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({stall_F, stall_D, stall_E, stall_M} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midwait_reset_drop: got %b want 0000", {stall_F, stall_D, stall_E, stall_M});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(o, e, a, b, c, d);
        n_checks++;
        if (o !== 7'b0000000) begin n_errors++; $display("FAIL midwait_run_after: got %b want 0000000", o); end
    endtask

    task automatic test_counters();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        logic [CW-1:0] want_s, want_f;
        do_reset();
        memtoreg_E = 1'b1; Rd_E = 4'd2; RegA_D = 4'd2; useA_D = 1'b1;
        run_cycle(o, e, a, b, c, d);
        set_idle();
        run_cycle(o, e, a, b, c, d);
        mem_req_M = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle(o, e, a, b, c, d);
        mem_ack = 1'b1;
        run_cycle(o, e, a, b, c, d);
        set_idle();
        run_cycle(o, e, a, b, c, d);
        branch_taken_E = 1'b1;
        run_cycle(o, e, a, b, c, d);
        set_idle();
        run_cycle(o, e, a, b, c, d);
`ifdef HAZARD_PERF_CNT_EN
        want_s = 4; want_f = 2;
`else
        want_s = 0; want_f = 0;
`endif
        n_checks++;
        if (a !== want_s) begin n_errors++; $display("FAIL stall_cnt: got %0d want %0d", a, want_s); end
        n_checks++;
        if (b !== want_f) begin n_errors++; $display("FAIL flush_cnt: got %0d want %0d", b, want_f); end
    endtask

    task automatic test_random();
        logic [6:0] o, e;
        logic [CW-1:0] a, b, c, d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            RegA_D = 4'($urandom_range(0, 3));
            RegB_D = 4'($urandom_range(0, 3));
            Rd_E   = 4'($urandom_range(0, 3));
            useA_D = 1'($urandom_range(0, 1));
            useB_D = 1'($urandom_range(0, 1));
            memtoreg_E     = 1'($urandom_range(0, 1));
            branch_taken_E = ($urandom_range(0, 4) == 0);
            mem_req_M      = ($urandom_range(0, 2) == 0);
            mem_ack        = ($urandom_range(0, 1) == 0);
            run_cycle(o, e, a, b, c, d);
            n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL rand_out_c%0d: got %b want %b", i, o, e); end
            n_checks++;
            if (a !== c || b !== d) begin
                n_errors++;
                $display("FAIL rand_cnt_c%0d: got %0d/%0d want %0d/%0d", i, a, b, c, d);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_midwait();
        test_counters();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
